// File: rtl/plc_mem_pkg.sv
// Shared definitions for the PLC program store: controller states, default
// widths and the word written by the power-up clear.
package plc_mem_pkg;

  localparam int IA_W_DEF = 16;
  localparam int ID_W_DEF = 24;

  // All-zero word doubles as the NOP instruction for the sequencer.
  localparam logic [ID_W_DEF-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram_1w1r.sv
// Program storage: one synchronous write port and one registered read port.
// The array itself carries no reset; only the read register is cleared.
module prog_ram_1w1r #(
  parameter int AW    = 4,
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its word until the next enabled read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/program_store_dp.sv
// PLC program store: clears memory after reset, serves instruction fetches in
// RUN and accepts a stream of load words at an auto-incrementing pointer in PROG.
//
// Load handshake: a word moves when L_VALID and L_READY are both 1 at a rising
// edge; L_READY depends only on state and L_ORG_WE, never on L_VALID.
module program_store_dp
  import plc_mem_pkg::*;
#(
  parameter int IA_W  = IA_W_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int DEPTH = 1 << IA_W
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            F_REQ,
  input  logic [IA_W-1:0] F_ADDR,
  input  logic            F_STALL,
  output logic [ID_W-1:0] F_DATA,
  output logic            F_VALID,
  input  logic            L_PROG,
  input  logic            L_ORG_WE,
  input  logic [IA_W-1:0] L_ORG,
  input  logic            L_VALID,
  input  logic [ID_W-1:0] L_DATA,
  output logic            L_READY,
  output logic [IA_W-1:0] L_PTR,
  output logic [ID_W-1:0] L_SUM,
  output logic            L_WRAP,
  output logic            BUSY,
  output state_t          STATE_DBG
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [ID_W-1:0] ZERO_WORD = ID_W'(NOP_WORD);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_q;
  logic [AW-1:0]   ptr_q;
  logic [ID_W-1:0] sum_q;
  logic            wrap_q;
  logic            fvalid_q;

  logic            org_load;
  logic            xfer;
  logic            fetch_take;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [ID_W-1:0] ram_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:   if (L_PROG)             state_d = ST_PROG;
      ST_PROG:  if (!L_PROG)            state_d = ST_RUN;
      default:                          state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_q <= clr_q + 1'b1;
      end
    end
  end

  // Origin load takes priority over a transfer by dropping L_READY that cycle.
  assign org_load   = L_ORG_WE && (state_q != ST_CLEAR);
  assign L_READY    = (state_q == ST_PROG) && !L_ORG_WE;
  assign xfer       = L_VALID && L_READY;
  assign fetch_take = (state_q == ST_RUN) && F_REQ && !F_STALL;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q  <= '0;
      sum_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && L_PROG) begin
        sum_q  <= '0;
        wrap_q <= 1'b0;
      end
      if (org_load) begin
        ptr_q <= L_ORG[AW-1:0];
      end else if (xfer) begin
        ptr_q <= ptr_q + 1'b1;
        sum_q <= sum_q ^ L_DATA;
        if (ptr_q == LAST_ADDR) begin
          wrap_q <= 1'b1;
        end
      end
    end
  end

  // A stalled consumer freezes the valid flag; the data register freezes in the RAM.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fvalid_q <= 1'b0;
    end else if (!F_STALL) begin
      fvalid_q <= fetch_take;
    end
  end

  // Writes are gated by RST_N so the reset cycle never disturbs the array.
  assign ram_we    = RST_N && ((state_q == ST_CLEAR) || xfer);
  assign ram_waddr = (state_q == ST_CLEAR) ? clr_q : ptr_q;
  assign ram_wdata = (state_q == ST_CLEAR) ? ZERO_WORD : L_DATA;

  prog_ram_1w1r #(
    .AW    (AW),
    .DW    (ID_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (fetch_take),
    .raddr (F_ADDR[AW-1:0]),
    .rdata (F_DATA)
  );

  assign F_VALID   = fvalid_q;
  assign L_PTR     = IA_W'(ptr_q);
  assign L_SUM     = sum_q;
  assign L_WRAP    = wrap_q;
  assign BUSY      = (state_q == ST_CLEAR);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_program_store_dp.sv
// Bench for program_store_dp: directed scenarios plus random traffic, checked
// against a word-array model with a fetch scoreboard.
module tb_program_store_dp;

  localparam int IA_W  = 4;
  localparam int ID_W  = 24;
  localparam int DEPTH = 16;

  typedef enum int {M_CLEAR, M_RUN, M_PROG} mode_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            f_req = 1'b0;
  logic [IA_W-1:0] f_addr = '0;
  logic            f_stall = 1'b0;
  logic            l_prog = 1'b0;
  logic            l_org_we = 1'b0;
  logic [IA_W-1:0] l_org = '0;
  logic            l_valid = 1'b0;
  logic [ID_W-1:0] l_data = '0;
  logic [ID_W-1:0] f_data;
  logic            f_valid;
  logic            l_ready;
  logic [IA_W-1:0] l_ptr;
  logic [ID_W-1:0] l_sum;
  logic            l_wrap;
  logic            busy;
  plc_mem_pkg::state_t dbg_state;

  program_store_dp #(.IA_W(IA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_N(rst_n),
    .F_REQ(f_req), .F_ADDR(f_addr), .F_STALL(f_stall),
    .F_DATA(f_data), .F_VALID(f_valid),
    .L_PROG(l_prog), .L_ORG_WE(l_org_we), .L_ORG(l_org),
    .L_VALID(l_valid), .L_DATA(l_data), .L_READY(l_ready),
    .L_PTR(l_ptr), .L_SUM(l_sum), .L_WRAP(l_wrap),
    .BUSY(busy), .STATE_DBG(dbg_state)
  );

  // reference model and scoreboard
  mode_t           m_mode = M_CLEAR;
  int              m_clr = 0;
  logic [ID_W-1:0] m_mem [DEPTH];
  int              m_ptr = 0;
  logic [ID_W-1:0] m_sum = '0;
  bit              m_wrap = 1'b0;
  bit              m_known = 1'b0;
  logic [ID_W-1:0] exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: checks registered outputs from the last edge, applies new inputs,
  // then advances the model across the coming edge
  task automatic drive(input bit rst, input bit req, input int fa, input bit stall,
                       input bit prog, input bit owe, input int org,
                       input bit lv, input logic [ID_W-1:0] ld);
    @(negedge clk);
    if (m_known) begin
      cmp("busy",   32'(busy),   32'(m_mode == M_CLEAR));
      cmp("l_ptr",  32'(l_ptr),  32'(m_ptr));
      cmp("l_sum",  32'(l_sum),  32'(m_sum));
      cmp("l_wrap", 32'(l_wrap), 32'(m_wrap));
    end
    rst_n    = rst;
    f_req    = req;
    f_addr   = IA_W'(fa);
    f_stall  = stall;
    l_prog   = prog;
    l_org_we = owe;
    l_org    = IA_W'(org);
    l_valid  = lv;
    l_data   = ld;
    #1;
    if (m_known) cmp("l_ready", 32'(l_ready), 32'(m_mode == M_PROG && !owe));
    if (!rst) begin
      m_mode = M_CLEAR; m_clr = 0; m_ptr = 0; m_sum = '0; m_wrap = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      case (m_mode)
        M_CLEAR: begin
          m_mem[m_clr] = '0;
          m_clr++;
          if (m_clr == DEPTH) m_mode = M_RUN;
        end
        M_RUN: begin
          if (req && !stall) exp_q.push_back(m_mem[fa % DEPTH]);
          if (owe) m_ptr = org % DEPTH;
          if (prog) begin m_mode = M_PROG; m_sum = '0; m_wrap = 1'b0; end
        end
        default: begin
          if (owe) m_ptr = org % DEPTH;
          else if (lv) begin
            m_mem[m_ptr] = ld;
            m_sum = m_sum ^ ld;
            m_ptr = m_ptr + 1;
            if (m_ptr == DEPTH) begin m_ptr = 0; m_wrap = 1'b1; end
          end
          if (!prog) m_mode = M_RUN;
        end
      endcase
    end
  endtask

  task automatic idle(input int n, input bit prog);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, prog, 0, 0, 0, '0);
  endtask
  task automatic fetch(input int a);            drive(1, 1, a, 0, 0, 0, 0, 0, '0); endtask
  task automatic load(input logic [ID_W-1:0] d); drive(1, 0, 0, 0, 1, 0, 0, 1, d);  endtask
  task automatic set_org(input int o);          drive(1, 0, 0, 0, 1, 1, o, 0, '0); endtask

  task automatic expect_regs(input string tag, input int ptr, input logic [ID_W-1:0] sum, input bit wrap);
    @(posedge clk);
    #1;
    cmp({tag, "_ptr"},  32'(l_ptr),  32'(ptr));
    cmp({tag, "_sum"},  32'(l_sum),  32'(sum));
    cmp({tag, "_wrap"}, 32'(l_wrap), 32'(wrap));
  endtask

  // monitor: compares fetch outputs one step after every rising edge
  initial begin
    logic [ID_W-1:0] prev_data;
    logic            prev_valid;
    logic [ID_W-1:0] e;
    prev_data  = '0;
    prev_valid = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cmp("rst_f_valid", 32'(f_valid), 32'd0);
        cmp("rst_f_data",  32'(f_data),  32'd0);
      end else if (f_stall) begin
        cmp("stall_f_valid", 32'(f_valid), 32'(prev_valid));
        cmp("stall_f_data",  32'(f_data),  32'(prev_data));
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("fetch_valid", 32'(f_valid), 32'd1);
        cmp("fetch_data",  32'(f_data),  32'(e));
      end else begin
        cmp("idle_f_valid", 32'(f_valid), 32'd0);
        cmp("idle_f_data",  32'(f_data),  32'(prev_data));
      end
      prev_data  = f_data;
      prev_valid = f_valid;
    end
  end

  initial begin
    bit prog_r;
    // reset and power-up clear, with fetch requests that must be dropped
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, i, 0, 0, 0, 0, 0, '0);
    for (int a = 0; a < DEPTH; a++) fetch(a);
    idle(1, 0);

    // origin 3, three loads, fetch in first RUN cycle after PROG
    idle(1, 1);
    set_org(3);
    load(24'h010001);
    load(24'h0A0001);
    load(24'h0F0000);
    idle(1, 0);
    fetch(4);
    idle(1, 0);
    expect_regs("org3", 6, 24'h040000, 1'b0);

    // pointer wrap from the top of memory
    idle(1, 1);
    set_org(14);
    load(24'h123456);
    load(24'h00ABCD);
    load(24'hFEDCBA);
    idle(1, 0);
    expect_regs("wrap", 1, 24'h123456 ^ 24'h00ABCD ^ 24'hFEDCBA, 1'b1);
    fetch(14);
    fetch(15);
    fetch(0);
    idle(1, 1);
    expect_regs("reprog", 1, 24'h0, 1'b0);
    idle(1, 0);

    // stall holds the addr-5 word while addr 9 is requested
    fetch(5);
    for (int i = 0; i < 3; i++) drive(1, 1, 9, 1, 0, 0, 0, 0, '0);
    drive(1, 1, 9, 0, 0, 0, 0, 0, '0);
    idle(2, 0);

    // fetch in the RUN->PROG transition cycle is still served
    drive(1, 1, 4, 0, 1, 0, 0, 0, '0);
    idle(2, 0);

    // random traffic
    prog_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) prog_r = ~prog_r;
      drive(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, prog_r, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ID_W'($urandom()));
    end
    idle(2, 0);

    // reset mid-PROG, then clear with L_PROG held high the whole time
    idle(1, 1);
    load(24'hAAAAAA);
    load(24'h555555);
    drive(0, 0, 0, 0, 1, 0, 0, 0, '0);
    expect_regs("midrst", 0, 24'h0, 1'b0);
    cmp("midrst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, i, 0, 1, 0, 0, 0, '0);
    idle(1, 1);
    idle(1, 0);
    for (int a = 0; a < DEPTH; a++) fetch(a);
    idle(2, 0);

    done = 1'b1;
    @(posedge clk);
    #2;
    cmp("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
